// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register slave.
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE_S,
      ADDR_S,
      ADDR_ACK_S,
      PTR_S,
      PTR_ACK_S,
      WR_S,
      WR_ACK_S,
      RD_S,
      RD_ACK_S,
      WAIT_STOP_S
   } state_t;

   localparam logic ACK       = 1'b0;
   localparam logic NACK      = 1'b1;
   localparam int   BIT_CNT_W = 4;

   function automatic logic maj3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

endpackage

// File: rtl/i2c_slave_sync_edge.sv
// Bus-line synchroniser and SCL edge / START / STOP detector.
// Define I2C_SLAVE_GLITCH_FILTER_EN to add a 3-sample majority filter.
module i2c_slave_sync_edge
   import i2c_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_scl,
   input  logic i_sda,
   output logic o_sda,
   output logic o_scl_rise,
   output logic o_scl_fall,
   output logic o_start,
   output logic o_stop
);

   logic [1:0] r_scl_sync, r_sda_sync;
   logic       r_scl_d, r_sda_d;
   logic       w_scl, w_sda;

   // Reset to 1 so an idle bus produces no spurious edges
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scl_sync <= 2'b11;
         r_sda_sync <= 2'b11;
      end else begin
         r_scl_sync <= {r_scl_sync[0], i_scl};
         r_sda_sync <= {r_sda_sync[0], i_sda};
      end
   end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
   logic [2:0] r_scl_flt, r_sda_flt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scl_flt <= 3'b111;
         r_sda_flt <= 3'b111;
      end else begin
         r_scl_flt <= {r_scl_flt[1:0], r_scl_sync[1]};
         r_sda_flt <= {r_sda_flt[1:0], r_sda_sync[1]};
      end
   end

   assign w_scl = maj3(r_scl_flt);
   assign w_sda = maj3(r_sda_flt);
`else
   assign w_scl = r_scl_sync[1];
   assign w_sda = r_sda_sync[1];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scl_d <= 1'b1;
         r_sda_d <= 1'b1;
      end else begin
         r_scl_d <= w_scl;
         r_sda_d <= w_sda;
      end
   end

   assign o_sda      = w_sda;
   assign o_scl_rise = w_scl & ~r_scl_d;
   assign o_scl_fall = ~w_scl & r_scl_d;
   assign o_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
   assign o_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

endmodule

// File: rtl/i2c_slave.sv
// I2C slave: pointer-write then data write/read via a simple register port.
// Optional input glitch filter: define I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0] I2C_SLAVE_ADDR = 7'h1A,
   parameter logic       ACK_VAL        = ACK,
   parameter int         REG_ADDR_W     = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  scl,
   inout  wire                   sda,
   output logic                  reg_wr_en,
   output logic                  reg_rd_en,
   output logic [REG_ADDR_W-1:0] reg_addr,
   output logic [7:0]            reg_wr_data,
   input  logic [7:0]            reg_rd_data,
   input  logic                  reg_rd_valid,
   output logic                  busy
);

   state_t                r_state;
   logic [BIT_CNT_W-1:0]  r_cnt;
   logic [7:0]            r_shift, r_tx;
   logic                  r_rw, r_mack, r_pend;
   logic                  r_sda_oe, r_sda_lvl;
   logic [REG_ADDR_W-1:0] r_ptr;
   logic                  r_wr_en, r_rd_en, r_busy;
   logic [7:0]            r_wr_data;

   logic       w_sda, w_rise, w_fall, w_start, w_stop;
   logic       w_bit_done;
   logic [7:0] w_rx_byte, w_tx_byte;

   i2c_slave_sync_edge u_sync (
      .clk        (clk),
      .rst        (rst),
      .i_scl      (scl),
      .i_sda      (sda),
      .o_sda      (w_sda),
      .o_scl_rise (w_rise),
      .o_scl_fall (w_fall),
      .o_start    (w_start),
      .o_stop     (w_stop)
   );

   assign w_bit_done = (r_cnt == BIT_CNT_W'(8));
   assign w_rx_byte  = {r_shift[6:0], w_sda};
   // Read data that has not arrived by the first falling edge goes out as all ones
   assign w_tx_byte  = r_pend ? 8'hFF : r_tx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE_S;
         r_cnt     <= '0;
         r_shift   <= '0;
         r_tx      <= 8'hFF;
         r_rw      <= 1'b0;
         r_mack    <= 1'b0;
         r_pend    <= 1'b0;
         r_sda_oe  <= 1'b0;
         r_sda_lvl <= 1'b0;
         r_ptr     <= '0;
         r_wr_en   <= 1'b0;
         r_rd_en   <= 1'b0;
         r_wr_data <= '0;
         r_busy    <= 1'b0;
      end else begin
         r_wr_en <= 1'b0;
         r_rd_en <= 1'b0;
         if (reg_rd_valid && r_pend) begin
            r_tx   <= reg_rd_data;
            r_pend <= 1'b0;
         end
         if (w_stop) begin
            r_state  <= IDLE_S;
            r_cnt    <= '0;
            r_sda_oe <= 1'b0;
            r_pend   <= 1'b0;
            r_busy   <= 1'b0;
         end else if (w_start) begin
            r_state  <= ADDR_S;
            r_cnt    <= '0;
            r_sda_oe <= 1'b0;
            r_pend   <= 1'b0;
         end else begin
            case (r_state)
               IDLE_S, WAIT_STOP_S: ;
               ADDR_S, PTR_S, WR_S: begin
                  if (w_rise) begin
                     r_shift <= w_rx_byte;
                     r_cnt   <= r_cnt + 1'b1;
                     if (r_state == WR_S && r_cnt == BIT_CNT_W'(7)) begin
                        r_wr_en   <= 1'b1;
                        r_wr_data <= w_rx_byte;
                     end
                  end else if (w_fall && w_bit_done) begin
                     r_cnt     <= '0;
                     r_sda_oe  <= 1'b1;
                     r_sda_lvl <= ACK_VAL;
                     if (r_state == PTR_S) begin
                        r_ptr   <= REG_ADDR_W'(r_shift);
                        r_state <= PTR_ACK_S;
                     end else if (r_state == WR_S) begin
                        r_state <= WR_ACK_S;
                     end else if (r_shift[7:1] == I2C_SLAVE_ADDR) begin
                        r_rw    <= r_shift[0];
                        r_busy  <= 1'b1;
                        r_state <= ADDR_ACK_S;
                     end else begin
                        r_sda_oe <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= WAIT_STOP_S;
                     end
                  end
               end
               ADDR_ACK_S: begin
                  // Request read data during the ACK clock so it is ready for the MSB
                  if (w_rise && r_rw) begin
                     r_rd_en <= 1'b1;
                     r_pend  <= 1'b1;
                  end else if (w_fall) begin
                     r_cnt <= '0;
                     if (r_rw) begin
                        r_state   <= RD_S;
                        r_sda_oe  <= ~w_tx_byte[7];
                        r_sda_lvl <= 1'b0;
                        r_tx      <= {w_tx_byte[6:0], 1'b1};
                        r_pend    <= 1'b0;
                     end else begin
                        r_state  <= PTR_S;
                        r_sda_oe <= 1'b0;
                     end
                  end
               end
               PTR_ACK_S: begin
                  if (w_fall) begin
                     r_sda_oe <= 1'b0;
                     r_state  <= WR_S;
                  end
               end
               WR_ACK_S: begin
                  if (w_fall) begin
                     r_sda_oe <= 1'b0;
                     r_ptr    <= r_ptr + 1'b1;
                     r_state  <= WR_S;
                  end
               end
               RD_S: begin
                  if (w_rise) begin
                     r_cnt <= r_cnt + 1'b1;
                  end else if (w_fall) begin
                     if (w_bit_done) begin
                        r_cnt    <= '0;
                        r_sda_oe <= 1'b0;
                        r_state  <= RD_ACK_S;
                     end else begin
                        r_sda_oe <= ~r_tx[7];
                        r_tx     <= {r_tx[6:0], 1'b1};
                     end
                  end
               end
               RD_ACK_S: begin
                  if (w_rise) begin
                     r_mack <= (w_sda == ACK_VAL);
                     if (w_sda == ACK_VAL) begin
                        r_ptr   <= r_ptr + 1'b1;
                        r_rd_en <= 1'b1;
                        r_pend  <= 1'b1;
                     end
                  end else if (w_fall) begin
                     if (r_mack) begin
                        r_state   <= RD_S;
                        r_sda_oe  <= ~w_tx_byte[7];
                        r_sda_lvl <= 1'b0;
                        r_tx      <= {w_tx_byte[6:0], 1'b1};
                        r_pend    <= 1'b0;
                     end else begin
                        r_state <= WAIT_STOP_S;
                     end
                  end
               end
               default: r_state <= IDLE_S;
            endcase
         end
      end
   end

   // Gating with rst releases the line in the same cycle reset asserts
   assign sda         = (r_sda_oe && !rst) ? r_sda_lvl : 1'bz;
   assign reg_wr_en   = r_wr_en;
   assign reg_rd_en   = r_rd_en;
   assign reg_addr    = r_ptr;
   assign reg_wr_data = r_wr_data;
   assign busy        = r_busy;

endmodule
